rv_stream_fifo: RTL

Parametrised valid/ready stream buffer: the next generation of the single-register `rv_protocol` handshake stage, carrying the operand and result streams between the systolic-MAC array and its feeders. Accepts words on a slave valid/ready port, stores up to `DEPTH` words, and presents them in order on a master valid/ready port with registered, first-word-fall-through output. Adds occupancy reporting, an almost-full flag, a synchronous flush, a handshake-beat pulse and a sticky protocol-violation flag.

---
 rtl/rv_stream_fifo.sv | 104 ++++++++++
 1 files changed

// File: rtl/rv_stream_fifo.sv
// Valid/ready stream FIFO with registered first-word-fall-through output,
// occupancy, almost-full, flush, fire pulse and sticky protocol-error flag.
module rv_stream_fifo #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_fire,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       afull,
  output logic                       err_proto
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_next;
  logic [CW-1:0]     count_next;
  logic [DATA_W-1:0] head_next;
  logic [DATA_W-1:0] prev_data;
  logic              prev_stall;
  logic              push;
  logic              pop;

  assign push   = s_valid & s_ready;
  assign pop    = m_valid & m_ready;
  assign m_fire = pop;

  assign rd_next = rd_ptr + PW'(pop);

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  // Word arriving into an otherwise-empty buffer becomes the new head.
  always_comb begin
    head_next = mem[rd_next];
    if (count == CW'(pop))
      head_next = s_data;
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      afull      <= 1'b0;
      err_proto  <= 1'b0;
      prev_stall <= 1'b0;
      prev_data  <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      s_ready    <= 1'b1;
      m_valid    <= 1'b0;
      afull      <= 1'b0;
      err_proto  <= 1'b0;
      prev_stall <= 1'b0;
      prev_data  <= s_data;
    end else begin
      wr_ptr     <= wr_ptr + PW'(push);
      rd_ptr     <= rd_next;
      count      <= count_next;
      s_ready    <= count_next < DEPTH_C;
      m_valid    <= count_next != '0;
      afull      <= count_next >= AFULL_C;
      if (count_next != '0)
        m_data   <= head_next;
      prev_stall <= s_valid & ~s_ready;
      prev_data  <= s_data;
      // A stalled word must be held unchanged until accepted.
      if (prev_stall && (!s_valid || s_data != prev_data))
        err_proto <= 1'b1;
    end
  end

endmodule
